// File: rtl/gp_poll_master.sv
// GPIO switch poller: periodically reads the switch word, debounces it and mirrors stable changes to the LED register.
// Optional change interrupt enabled by defining GP_POLL_IRQ_EN; otherwise irq is tied low.
module gp_poll_master #(
  parameter int POLL_DIV = 50000,
  parameter int STABLE_N = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        read_en,
  input  logic [15:0] datar,
  output logic        memw,
  output logic [15:0] dataw,
  output logic [15:0] value,
  output logic        changed,
  output logic        busy,
  output logic        irq,
  input  logic        irq_ack
);

  localparam int DATA_W = 16;
  localparam int TMR_W  = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_DIV - 1);
  localparam logic [3:0]       CNT_MAX  = 4'(STABLE_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] value_q, value_d;

  logic [DATA_W-1:0] cand_upd;
  logic [3:0]        cnt_upd;
  logic              accept;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt < CNT_MAX) begin
      sat_inc = cnt + 4'd1;
    end else begin
      sat_inc = CNT_MAX;
    end
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Debounce update as seen by CHECK; the decision uses the post-update count
  always_comb begin
    cand_upd = cand_q;
    cnt_upd  = cnt_q;
    if (sample_q == cand_q) begin
      cnt_upd = sat_inc(cnt_q);
    end else begin
      cand_upd = sample_q;
      cnt_upd  = 4'd1;
    end
    accept = (cnt_upd == CNT_MAX) && (cand_upd != value_q);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (accept) begin
          state_d = S_WRITE;
        end else begin
          state_d = enable ? S_WAIT : S_IDLE;
        end
      end
      S_WRITE: begin
        state_d = enable ? S_WAIT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only; datar never reaches an output
  always_comb begin
    read_en = 1'b0;
    memw    = 1'b0;
    changed = 1'b0;
    dataw   = '0;
    busy    = (state_q != S_IDLE);
    value   = value_q;
    case (state_q)
      S_READ: begin
        read_en = 1'b1;
      end
      S_WRITE: begin
        memw    = 1'b1;
        changed = 1'b1;
        dataw   = cand_q;
      end
      default: begin
        read_en = 1'b0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    timer_d  = '0;
    sample_d = sample_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    if ((state_q == S_WAIT) && (timer_q != TMR_LAST)) begin
      timer_d = timer_q + TMR_W'(1);
    end
    if (state_q == S_READ) begin
      sample_d = datar;
    end
    if (state_q == S_CHECK) begin
      cand_d = cand_upd;
      cnt_d  = cnt_upd;
    end
    if (state_q == S_WRITE) begin
      value_d = cand_q;
    end
  end

  // Debounce state survives IDLE so a re-enable resumes where it left off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q  <= '0;
      sample_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
    end else begin
      timer_q  <= timer_d;
      sample_q <= sample_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
    end
  end

`ifdef GP_POLL_IRQ_EN
  logic irq_q, irq_d;

  // A new change outranks an acknowledge arriving on the same edge
  always_comb begin
    irq_d = irq_q;
    if (state_q == S_WRITE) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq = 1'b0;
`endif

  a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(read_en && memw));

endmodule

// File: tb/tb_gp_poll_master.sv
// Scoreboard bench for gp_poll_master (POLL_DIV=4, STABLE_N=3); expected writes come from a debounce model.
module tb_gp_poll_master;

  localparam int POLL_DIV = 4;
  localparam int STABLE_N = 3;
`ifdef GP_POLL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        read_en;
  logic [15:0] datar;
  logic        memw;
  logic [15:0] dataw;
  logic [15:0] value;
  logic        changed;
  logic        busy;
  logic        irq;
  logic        irq_ack;

  gp_poll_master #(.POLL_DIV(POLL_DIV), .STABLE_N(STABLE_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .read_en(read_en),
    .datar  (datar),
    .memw   (memw),
    .dataw  (dataw),
    .value  (value),
    .changed(changed),
    .busy   (busy),
    .irq    (irq),
    .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  int cycle_ctr = 0;
  always @(posedge clk) cycle_ctr <= cycle_ctr + 1;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] rd_hold;
  logic [15:0] m_cand, m_value;
  int          m_cnt;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  logic [15:0] last_dw;
  bit          saw7;
  bit          val_pend;
  logic [15:0] val_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: sample outputs at the falling edge, score writes, answer reads
  task automatic step();
    exp_t        e;
    logic [15:0] smp;
    @(negedge clk);
    if (reset) begin
      m_cand = '0; m_value = '0; m_cnt = 0;
      exp_q.delete();
      val_pend = 1'b0;
    end else begin
      if (read_en && memw) chk("strobe_excl", 32'(read_en & memw), 0);
      if (val_pend) begin
        chk("value_after_wr", value, val_exp);
        val_pend = 1'b0;
      end
      if (memw) begin
        n_wr++;
        last_dw = dataw;
        if (dataw == 16'h0007) saw7 = 1'b1;
        chk("changed_on_wr", changed, 1);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_wr", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_wr_data", dataw, e.data);
          chk("sb_wr_cycle", cycle_ctr, e.cyc);
          val_pend = 1'b1;
          val_exp  = e.data;
        end
      end else if (changed || (dataw != 16'h0)) begin
        chk("idle_changed_dataw", {15'h0, changed, dataw}, 0);
      end
      if (read_en) begin
        smp = (rd_q.size() > 0) ? rd_q.pop_front() : rd_hold;
        datar = smp;
        n_rd++;
        if (smp == m_cand) begin
          if (m_cnt < STABLE_N) m_cnt++;
        end else begin
          m_cand = smp;
          m_cnt  = 1;
        end
        if ((m_cnt == STABLE_N) && (m_cand != m_value)) begin
          exp_q.push_back('{m_cand, cycle_ctr + 2});
          m_value = m_cand;
        end
      end else begin
        datar = 16'hFFFF;
      end
    end
  endtask

  task automatic wait_wr(input int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (memw) return;
    end
    chk("wr_timeout", 0, 1);
  endtask

  task automatic wait_rd(input int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (read_en) return;
    end
    chk("rd_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rel, k, wr0, rd0;
    int rd_cyc_exp[4];
    rd_cyc_exp = '{5, 11, 17, 24};
    reset = 1'b1; enable = 1'b1; irq_ack = 1'b0; datar = 16'hFFFF; rd_hold = 16'h0;
    m_cand = '0; m_value = '0; m_cnt = 0; saw7 = 1'b0; val_pend = 1'b0; val_exp = '0; last_dw = '0;

    // Reset values, enable high the whole time
    repeat (6) begin
      step();
      chk("rst_read_en", read_en, 0);
      chk("rst_memw", memw, 0);
    end
    chk("rst_dataw", dataw, 0);
    chk("rst_value", value, 0);
    chk("rst_changed", changed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    enable = 1'b0;
    step();
    reset = 1'b0;
    step(); step();
    chk("idle_busy", busy, 0);

    // Stable 0x0005: reads at cycles 5/11/17/24, write at 19
    rd_hold = 16'h0005;
    enable = 1'b1;
    base = cycle_ctr;
    k = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      rel = cycle_ctr - base;
      if (read_en) begin
        chk("stable_rd_cycle", rel, (k < 4) ? rd_cyc_exp[k] : -1);
        k++;
      end
      if (memw) begin
        chk("stable_wr_cycle", rel, 19);
        chk("stable_wr_data", dataw, 16'h0005);
      end
      if (rel == 19) chk("stable_value_c19", value, 16'h0000);
      if (rel == 20) chk("stable_value_c20", value, 16'h0005);
    end
    chk("stable_n_reads", k, 4);

    // Bounce rejection
    wr0 = n_wr; rd0 = n_rd; saw7 = 1'b0;
    rd_q.push_back(16'h0003); rd_q.push_back(16'h0007); rd_q.push_back(16'h0003);
    rd_q.push_back(16'h0003); rd_q.push_back(16'h0003);
    rd_hold = 16'h0003;
    wait_wr(60);
    chk("bounce_reads_at_wr", n_rd - rd0, 5);
    chk("bounce_wr_data", dataw, 16'h0003);
    repeat (30) step();
    chk("bounce_n_wr", n_wr - wr0, 1);
    chk("bounce_no_0007", saw7, 0);

    // Zero from reset never written
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    rd_hold = 16'h0000;
    wr0 = n_wr; rd0 = n_rd;
    repeat (64) step();
    chk("zero_n_wr", n_wr - wr0, 0);
    chk("zero_reads_10", 32'(n_rd - rd0 >= 10), 1);
    chk("zero_value", value, 0);

    // Accepted 0x0005 held: one write, then silence
    rd_hold = 16'h0005;
    wait_wr(40);
    chk("hold_wr_data", dataw, 16'h0005);
    wr0 = n_wr;
    repeat (60) step();
    chk("hold_n_wr", n_wr - wr0, 0);

    // Disable during READ
    wait_rd(20);
    enable = 1'b0;
    rd0 = n_rd;
    step();
    chk("dis_check_busy", busy, 1);
    chk("dis_check_rd", read_en, 0);
    step();
    chk("dis_idle_busy", busy, 0);
    repeat (10) step();
    chk("dis_stays_idle", busy, 0);
    chk("dis_no_reads", n_rd - rd0, 0);

    // Reset during WRITE
    rd_hold = 16'h00A5;
    enable = 1'b1;
    wait_wr(40);
    chk("rstw_pre_value", value, 16'h0005);
    #2 reset = 1'b1;
    #1;
    chk("rstw_memw", memw, 0);
    chk("rstw_value", value, 0);
    chk("rstw_dataw", dataw, 0);
    chk("rstw_changed", changed, 0);
    step(); step();
    reset = 1'b0;

    // Interrupt set, set-wins over ack, ack clears
    chk("irq_after_rst", irq, 0);
    rd_hold = 16'h0011;
    wait_wr(40);
    chk("irq_in_write", irq, 0);
    step();
    chk("irq_set", irq, IRQ_ON);
    repeat (3) step();
    chk("irq_held", irq, IRQ_ON);
    rd_hold = 16'h0022;
    wait_wr(40);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("irq_set_wins", irq, IRQ_ON);
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("irq_ack_clears", irq, 0);
    step();
    chk("irq_stays_clear", irq, 0);

    enable = 1'b0;
    repeat (10) step();
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
